// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over 7 requesters with bounded grant tenure; the
// current owner's data bit is muxed combinationally onto 'out'.
module rr_mux_arbiter #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] req,
   input  logic [6:0] data,
   output logic [6:0] grant,
   output logic [2:0] sel,
   output logic       valid,
   output logic       out
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [7:0] CNT_MAX = 8'(HOLD_CYCLES - 1);

   state_t     state;
   logic [2:0] last;
   logic [7:0] cnt;
   logic [2:0] search_from;
   logic [2:0] winner;
   logic       release_now;

   // Scan from+1 .. from+6, then from itself, wrapping modulo 7.
   function automatic logic [2:0] next_owner(input logic [6:0] r, input logic [2:0] from);
      logic [2:0] idx;
      logic [2:0] w;
      logic       found;
      idx   = from;
      w     = from;
      found = 1'b0;
      for (int k = 0; k < 7; k++) begin
         idx = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
         if (!found && r[idx]) begin
            w     = idx;
            found = 1'b1;
         end
      end
      return w;
   endfunction

   always_comb begin
      search_from = (state == GRANT) ? sel : last;
      winner      = next_owner(req, search_from);
      release_now = !req[sel] || (cnt == CNT_MAX);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         sel   <= 3'd0;
         last  <= 3'd6;
         cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  sel   <= winner;
                  last  <= winner;
                  cnt   <= 8'd0;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (!release_now) begin
                  cnt <= cnt + 8'd1;
               end else if (|req) begin
                  // Hand over without an idle bubble; owner ranks last in the scan.
                  sel   <= winner;
                  last  <= winner;
                  cnt   <= 8'd0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs derive from state so an asynchronous reset clears them at once.
   always_comb begin
      valid = (state == GRANT);
      grant = valid ? (7'd1 << sel) : 7'd0;
      out   = valid & data[sel];
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomised and directed checks of rr_mux_arbiter against a rule-level
// arbitration model kept in the bench.
module tb_rr_mux_arbiter;

   localparam int HOLD = 4;

   logic       clock;
   logic       reset;
   logic [6:0] req;
   logic [6:0] data;
   logic [6:0] grant;
   logic [2:0] sel;
   logic       valid;
   logic       out;

   int errors;
   int checks;

   // Reference model: who owns the resource and for how long it has held it.
   bit m_active;
   int m_owner;
   int m_last;
   int m_tenure;

   rr_mux_arbiter #(.HOLD_CYCLES(HOLD)) dut (
      .clock(clock),
      .reset(reset),
      .req  (req),
      .data (data),
      .grant(grant),
      .sel  (sel),
      .valid(valid),
      .out  (out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int pick(input logic [6:0] r, input int from);
      for (int k = 1; k <= 7; k++) begin
         if (r[(from + k) % 7]) return (from + k) % 7;
      end
      return from;
   endfunction

   task automatic model_reset();
      m_active = 0;
      m_owner  = 0;
      m_last   = 6;
      m_tenure = 0;
   endtask

   task automatic model_step(input logic [6:0] r);
      if (!m_active) begin
         if (r != 0) begin
            m_owner  = pick(r, m_last);
            m_last   = m_owner;
            m_tenure = 0;
            m_active = 1;
         end
      end else if (r[m_owner] && m_tenure < HOLD - 1) begin
         m_tenure++;
      end else if (r != 0) begin
         m_owner  = pick(r, m_owner);
         m_last   = m_owner;
         m_tenure = 0;
      end else begin
         m_active = 0;
      end
   endtask

   // Drive one cycle of inputs at the falling edge, advance model, sample after the rising edge.
   task automatic cycle(input logic [6:0] r, input logic [6:0] d);
      @(negedge clock);
      req  = r;
      data = d;
      model_step(r);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      req   = 7'd0;
      data  = 7'h7f;
      model_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1;
      req   = 7'h7f;
      data  = 7'h7f;
      model_reset();
      #1;
      checks++;
      if (grant !== 7'd0 || valid !== 1'b0 || out !== 1'b0 || sel !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: grant=%b valid=%b out=%b sel=%0d, required 0000000/0/0/0", grant, valid, out, sel);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_first_grant();
      do_reset();
      cycle(7'b1000001, 7'b0000000);
      checks++;
      if (grant !== 7'b0000001 || sel !== 3'd0 || valid !== 1'b1) begin
         errors++;
         $display("FAIL first_grant: grant=%b sel=%0d valid=%b, required 0000001/0/1", grant, sel, valid);
      end
      checks++;
      if (out !== 1'b0) begin
         errors++;
         $display("FAIL out_data0_low: out=%b, required 0", out);
      end
      data = 7'b0000001;
      #1;
      checks++;
      if (out !== 1'b1) begin
         errors++;
         $display("FAIL out_data0_high: out=%b, required 1", out);
      end
      data = 7'b1111110;
      #1;
      checks++;
      if (out !== 1'b0) begin
         errors++;
         $display("FAIL out_other_bits: out=%b, required 0", out);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_sel;
      do_reset();
      for (int k = 0; k < 7 * HOLD + HOLD; k++) begin
         cycle(7'h7f, 7'h7f);
         exp_sel = 3'((k / HOLD) % 7);
         checks++;
         if (sel !== exp_sel || valid !== 1'b1 || grant !== (7'd1 << exp_sel)) begin
            errors++;
            $display("FAIL round_robin cycle %0d: sel=%0d valid=%b grant=%b, required sel=%0d valid=1", k, sel, valid, grant, exp_sel);
         end
      end
   endtask

   task automatic test_drop();
      do_reset();
      cycle(7'b0100100, 7'd0);
      checks++;
      if (sel !== 3'd2 || valid !== 1'b1) begin
         errors++;
         $display("FAIL drop_owner2: sel=%0d valid=%b, required 2/1", sel, valid);
      end
      cycle(7'b0100000, 7'b0100000);
      checks++;
      if (sel !== 3'd5 || valid !== 1'b1 || grant !== 7'b0100000 || out !== 1'b1) begin
         errors++;
         $display("FAIL drop_handover: sel=%0d valid=%b grant=%b out=%b, required 5/1/0100000/1", sel, valid, grant, out);
      end
   endtask

   task automatic test_single();
      do_reset();
      for (int k = 0; k < 3 * HOLD; k++) begin
         cycle(7'b0001000, 7'b0001000);
         checks++;
         if (sel !== 3'd3 || valid !== 1'b1 || out !== 1'b1) begin
            errors++;
            $display("FAIL single_req cycle %0d: sel=%0d valid=%b out=%b, required 3/1/1", k, sel, valid, out);
         end
      end
   endtask

   task automatic test_idle_wrap();
      do_reset();
      cycle(7'b0010000, 7'h7f);
      checks++;
      if (sel !== 3'd4 || valid !== 1'b1) begin
         errors++;
         $display("FAIL idle_owner4: sel=%0d valid=%b, required 4/1", sel, valid);
      end
      cycle(7'b0000000, 7'h7f);
      checks++;
      if (valid !== 1'b0 || grant !== 7'd0 || out !== 1'b0 || sel !== 3'd4) begin
         errors++;
         $display("FAIL idle_drop: valid=%b grant=%b out=%b sel=%0d, required 0/0000000/0/4", valid, grant, out, sel);
      end
      cycle(7'b0010001, 7'h7f);
      checks++;
      if (sel !== 3'd0 || grant !== 7'b0000001 || valid !== 1'b1) begin
         errors++;
         $display("FAIL idle_wrap: sel=%0d grant=%b valid=%b, required 0/0000001/1", sel, grant, valid);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      cycle(7'h7f, 7'h7f);
      cycle(7'h7f, 7'h7f);
      cycle(7'h7f, 7'h7f);
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (grant !== 7'd0 || valid !== 1'b0 || out !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: grant=%b valid=%b out=%b, required 0000000/0/0", grant, valid, out);
      end
      #3;
      reset = 1'b0;
      model_step(req);
      @(posedge clock);
      #1;
      checks++;
      if (grant !== 7'b0000001 || sel !== 3'd0 || valid !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_regrant: grant=%b sel=%0d valid=%b, required 0000001/0/1", grant, sel, valid);
      end
   endtask

   task automatic test_random();
      logic [6:0] r;
      logic [6:0] d;
      logic [6:0] exp_grant;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         r = 7'($urandom) & 7'($urandom);
         if ($urandom_range(0, 3) == 0) r = 7'($urandom);
         d = 7'($urandom);
         cycle(r, d);
         exp_grant = m_active ? (7'd1 << m_owner) : 7'd0;
         checks++;
         if (grant !== exp_grant || valid !== logic'(m_active) || sel !== 3'(m_owner)) begin
            errors++;
            $display("FAIL random cycle %0d: grant=%b valid=%b sel=%0d, required %b/%b/%0d", k, grant, valid, sel, exp_grant, m_active, m_owner);
         end
         data = 7'($urandom);
         #1;
         checks++;
         if (out !== logic'(m_active && data[m_owner])) begin
            errors++;
            $display("FAIL random_out cycle %0d: out=%b, required %b", k, out, m_active && data[m_owner]);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      req    = 7'd0;
      data   = 7'd0;
      model_reset();
      test_reset();
      test_first_grant();
      test_round_robin();
      test_drop();
      test_single();
      test_idle_wrap();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
